// File: rtl/player_input_conditioner.sv
// player_input_conditioner
//   Turns 16 raw paddle switches into a clean one-hot swing vector for the
//   pong game core. Each switch is synchronized, debounced and rising-edge
//   detected. A press produces one fixed-length one-hot pulse followed by a
//   cooldown window. Presses that arrive while a swing is active are dropped.
//
// Ports
//   clk      in   1   system clock
//   reset    in   1   asynchronous, active-high reset
//   sw_raw   in   16  raw switch levels, asynchronous to clk
//   enable   in   1   1 = swings accepted
//   player   out  16  one-hot swing vector, 0 when idle
//   hit      out  1   single-cycle strobe when player becomes nonzero
//   hit_idx  out  4   index of the served switch, held until the next hit
//   busy     out  1   1 while a pulse or cooldown is in progress
//
// States
//   ST_IDLE  | waiting for a debounced rising edge while enabled
//   ST_PULSE | player held one-hot for PULSE_CYCLES cycles
//   ST_COOL  | dead time before the next swing may be accepted

module player_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 25000000,
  parameter int COOLDOWN_CYCLES = 12500000,
  parameter int CNT_W           = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw_raw,
  input  logic        enable,
  output logic [15:0] player,
  output logic        hit,
  output logic [3:0]  hit_idx,
  output logic        busy
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam int               COOL_LAST_I = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_LAST_I);
  localparam bit               HAS_COOL   = (COOLDOWN_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  logic [15:0]            s1_q, s2_q;
  logic [15:0]            stable_q, stable_d;
  logic [15:0]            stable_dly_q;
  logic [15:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [15:0]            rise;
  logic [3:0]             rise_idx;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [15:0]            player_q, player_d;
  logic                   hit_q, hit_d;
  logic [3:0]             hit_idx_q, hit_idx_d;
  logic                   busy_q, busy_d;

  // Two-flop synchronizer for the asynchronous switch levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce: counter runs only while the synchronized level differs
  // from the accepted level; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < 16; i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign rise = stable_q & ~stable_dly_q;

  // Lowest set index wins; scanning downward lets the lowest overwrite last.
  always_comb begin
    rise_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rise[i]) begin
        rise_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    player_d  = player_q;
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && (|rise)) begin
          player_d  = 16'd1 << rise_idx;
          hit_d     = 1'b1;
          hit_idx_d = rise_idx;
          cnt_d     = PULSE_LAST;
          state_d   = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (!enable) begin
          player_d = '0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (cnt_q == '0) begin
          player_d = '0;
          if (HAS_COOL) begin
            cnt_d   = COOL_LAST;
            state_d = ST_COOL;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COOL: begin
        if (!enable || (cnt_q == '0)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        player_d = '0;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      player_q  <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      player_q  <= player_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign player  = player_q;
  assign hit     = hit_q;
  assign hit_idx = hit_idx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_player_input_conditioner.sv
// tb_player_input_conditioner
//   Drives player_input_conditioner with directed scenarios and random switch
//   activity. A timestamp-based reference model predicts every output each
//   cycle; literal expectations pin the model on the key scenarios.

module tb_player_input_conditioner;

  localparam int DB = 4;
  localparam int PW = 8;
  localparam int CD = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_raw;
  logic        enable;
  logic [15:0] player;
  logic        hit;
  logic [3:0]  hit_idx;
  logic        busy;

  int total_checks = 0;
  int passed_checks = 0;

  player_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (PW),
    .COOLDOWN_CYCLES(CD),
    .CNT_W          (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .enable (enable),
    .player (player),
    .hit    (hit),
    .hit_idx(hit_idx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: swings described by their start edge, windows derived
  // from start + pulse length + cooldown length.
  int          cyc = 0;
  logic [15:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_prev = '0;
  int          m_run [16];
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [3:0]  m_idx = '0;
  logic [15:0] e_player = '0;
  logic        e_hit = 1'b0;
  logic        e_busy = 1'b0;

  always @(posedge clk) begin
    logic [15:0] rise;
    logic [15:0] old_stable;
    bit          idle_before, found;
    int          n;
    cyc++;
    n = cyc;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
      m_active = 1'b0;
      m_idx = '0;
      e_player = '0; e_hit = 1'b0; e_busy = 1'b0;
    end else begin
      rise = m_stable & ~m_prev;
      idle_before = !(m_active && (n - 1) <= m_start + PW + CD - 1);
      if (!idle_before && !enable) begin
        m_active = 1'b0;
      end else if (idle_before && enable && rise != 0) begin
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
          if (!found && rise[i]) begin
            m_idx = 4'(i);
            found = 1'b1;
          end
        end
        m_active = 1'b1;
        m_start  = n;
      end
      // A level is accepted once it has disagreed for DB consecutive edges.
      old_stable = m_stable;
      for (int i = 0; i < 16; i++) begin
        if (m_s2[i] == m_stable[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= DB) begin
          m_stable[i] = m_s2[i];
          m_run[i] = 0;
        end else m_run[i] = m_run[i] + 1;
      end
      m_prev = old_stable;
      m_s2 = m_s1;
      m_s1 = sw_raw;
      e_player = (m_active && n <= m_start + PW - 1) ? (16'd1 << m_idx) : 16'd0;
      e_hit    = m_active && (n == m_start);
      e_busy   = m_active && (n <= m_start + PW + CD - 1);
    end
  end

  always @(posedge clk) begin
    #1;
    check("cycle_outputs", {10'd0, player, hit, hit_idx, busy},
          {10'd0, e_player, e_hit, m_idx, e_busy});
  end

  task automatic obs(input int n, input logic [15:0] pat, output int first,
                     output int pc, output int other, output int hc, output int bc);
    first = -1; pc = 0; other = 0; hc = 0; bc = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (player != 0 && first < 0) first = k;
      if (player == pat) pc++;
      else if (player != 0) other++;
      if (hit) hc++;
      if (busy) bc++;
    end
  endtask

  int first, pc, other, hc, bc;

  initial begin
    for (int i = 0; i < 16; i++) m_run[i] = 0;
    reset = 1'b1;
    sw_raw = '0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_player", {16'd0, player}, 32'd0);
    check("reset_hit", {31'd0, hit}, 32'd0);
    check("reset_hit_idx", {28'd0, hit_idx}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Clean press on bit 8.
    sw_raw[8] = 1'b1;
    obs(25, 16'h0100, first, pc, other, hc, bc);
    check("t1_first_edge", first, 6);
    check("t1_pulse_width", pc, 8);
    check("t1_other", other, 0);
    check("t1_hits", hc, 1);
    check("t1_busy_cycles", bc, 14);
    check("t1_hit_idx", {28'd0, hit_idx}, 32'd8);
    @(negedge clk); sw_raw = '0;
    repeat (25) @(negedge clk);

    // Three-cycle glitch on bit 3.
    sw_raw[3] = 1'b1;
    repeat (3) @(negedge clk);
    sw_raw[3] = 1'b0;
    obs(20, 16'h0008, first, pc, other, hc, bc);
    check("t2_hits", hc, 0);
    check("t2_first", first, -1);
    @(negedge clk);

    // Simultaneous rises on bits 2 and 9.
    sw_raw = 16'h0204;
    obs(30, 16'h0004, first, pc, other, hc, bc);
    check("t3_pulse_width", pc, 8);
    check("t3_other", other, 0);
    check("t3_hits", hc, 1);
    check("t3_hit_idx", {28'd0, hit_idx}, 32'd2);
    obs(20, 16'h0200, first, pc, other, hc, bc);
    check("t3_bit9_never", hc, 0);
    @(negedge clk); sw_raw = '0;
    repeat (25) @(negedge clk);

    // Re-press on bit 5 lands in cooldown and is dropped.
    hc = 0;
    for (int k = 0; k < 40; k++) begin
      sw_raw[5] = (k < 7) || (k >= 13 && k < 30);
      @(posedge clk); #1;
      if (hit) hc++;
      @(negedge clk);
    end
    check("t4_cool_drop_hits", hc, 1);
    sw_raw = '0;
    repeat (10) @(negedge clk);
    sw_raw[5] = 1'b1;
    obs(25, 16'h0020, first, pc, other, hc, bc);
    check("t4_repress_width", pc, 8);
    check("t4_repress_hits", hc, 1);
    @(negedge clk); sw_raw = '0;
    repeat (25) @(negedge clk);

    // Disabled press, then enable dropped mid-pulse.
    enable = 1'b0;
    sw_raw[0] = 1'b1;
    obs(20, 16'h0001, first, pc, other, hc, bc);
    check("t5_disabled_hits", hc, 0);
    @(negedge clk); sw_raw = '0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    sw_raw[1] = 1'b1;
    obs(9, 16'h0002, first, pc, other, hc, bc);
    check("t5_pulse_started", pc, 3);
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    check("t5_abort_player", {16'd0, player}, 32'd0);
    check("t5_abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); enable = 1'b1; sw_raw = '0;
    repeat (25) @(negedge clk);

    // Async reset mid-pulse, bit 0 held through reset release.
    sw_raw[4] = 1'b1;
    obs(9, 16'h0010, first, pc, other, hc, bc);
    check("t6_pulse_started", pc, 3);
    #2;
    reset = 1'b1;
    sw_raw = 16'h0001;
    #1;
    check("t6_async_player", {16'd0, player}, 32'd0);
    check("t6_async_hit_idx", {28'd0, hit_idx}, 32'd0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs(30, 16'h0001, first, pc, other, hc, bc);
    check("t6_single_swing_hits", hc, 1);
    check("t6_single_swing_width", pc, 8);
    check("t6_first_edge", first, 6);
    @(negedge clk); sw_raw = '0;
    repeat (25) @(negedge clk);

    // Random switch and enable activity.
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      int hold;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        int b;
        b = $urandom_range(0, 15);
        sw_raw[b] = ~sw_raw[b];
      end else if (r == 6) begin
        int b1, b2;
        b1 = $urandom_range(0, 15);
        b2 = $urandom_range(0, 15);
        sw_raw[b1] = ~sw_raw[b1];
        sw_raw[b2] = ~sw_raw[b2];
      end else if (r == 7) begin
        enable = ~enable;
      end else if (!enable) begin
        enable = 1'b1;
      end
      hold = $urandom_range(1, 12);
      repeat (hold) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
